seed_load_sequencer: RTL and testbench

- Sits in the user_clk domain behind the seed_data software register (the 32-bit user_data_out of the register block).
- Detects a settled new seed value, waits for the next system sync pulse, then loads a per-lane derived seed into N_LANES noise-generator lanes.
- Loads lanes serially, one lane per accepted valid/ready transfer.
- Reports busy, completion and a load counter for readback through a status register.

---
 rtl/seed_load_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_seed_load_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seed_load_sequencer.sv
// seed_load_sequencer
// Watches the seed_data software register. When it holds a new value that has
// settled, the block waits for the next system sync pulse and then loads a
// per-lane derived seed into each noise-generator lane, one lane per accepted
// valid/ready transfer. Busy, a completion pulse and a load counter are
// provided for status readback.
//
// Optional build macro: SEED_LOAD_TIMEOUT_EN
//   defined   -> WAIT_SYNC gives up after SYNC_TO_CYCLES cycles and starts
//                the load anyway, flagging sync_timeout.
//   undefined -> WAIT_SYNC waits for sync indefinitely; sync_timeout stays 0.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | seed_reg matches the last loaded seed; nothing to do
// SETTLE    | seed_reg differs; waiting for it to hold steady
// WAIT_SYNC | new seed latched; waiting for the system sync pulse
// LOAD      | presenting lane seeds on the ld_* handshake, one per accept
// DONE      | one-cycle completion: pulse load_done, bump load_count

module seed_load_sequencer #(
    parameter int N_LANES        = 8,
    parameter int LANE_W         = 3,
    parameter int STABLE_CYCLES  = 4,
    parameter int SYNC_TO_CYCLES = 1024
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic [31:0]       seed_reg,
    input  logic              sync_in,
    output logic              ld_valid,
    output logic [LANE_W-1:0] ld_lane,
    output logic [31:0]       ld_seed,
    input  logic              ld_ready,
    output logic              busy,
    output logic              load_done,
    output logic [15:0]       load_count,
    output logic              sync_timeout
);

    // Golden-ratio increment spreads the lane seeds across the 32-bit space.
    localparam logic [31:0]       GOLDEN     = 32'h9E3779B9;
    localparam logic [7:0]        STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(N_LANES - 1);

    // Elaboration-time sanity check of the parameter set.
    if (N_LANES < 2 || N_LANES > 256 || LANE_W != $clog2(N_LANES) ||
        STABLE_CYCLES < 1 || STABLE_CYCLES > 255 || SYNC_TO_CYCLES < 1) begin : g_param_check
        $error("seed_load_sequencer: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETTLE    = 3'd1,
        WAIT_SYNC = 3'd2,
        LOAD      = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t              state_q;
    logic [31:0]         seed_prev_q;
    logic [7:0]          stab_cnt_q;
    logic [7:0]          stab_cnt_d;
    logic                settled;
    logic [31:0]         shadow_q;
    logic [31:0]         latch_q;
    logic [31:0]         acc_q;
    logic [31:0]         acc_d;
    logic [LANE_W-1:0]   lane_q;
    logic [LANE_W-1:0]   lane_d;
    logic                ld_valid_q;
    logic [31:0]         ld_seed_q;
    logic                busy_q;
    logic                load_done_q;
    logic [15:0]         load_count_q;
    logic                sync_timeout_q;
    logic                to_expired;

    // An all-zero seed would lock up an LFSR lane, so it is replaced by 1.
    function automatic logic [31:0] guard_zero(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

    // Stability counter: counts consecutive identical samples, saturating.
    always_comb begin
        stab_cnt_d = stab_cnt_q;
        if (seed_reg != seed_prev_q) begin
            stab_cnt_d = 8'd0;
        end else if (stab_cnt_q != STABLE_MAX) begin
            stab_cnt_d = stab_cnt_q + 8'd1;
        end
    end

    // Sample history and stability count registers.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            seed_prev_q <= 32'd0;
            stab_cnt_q  <= 8'd0;
        end else begin
            seed_prev_q <= seed_reg;
            stab_cnt_q  <= stab_cnt_d;
        end
    end

    // The current sample must also match, so a change on the very cycle the
    // count saturates is not latched.
    assign settled = (stab_cnt_q == STABLE_MAX) && (seed_reg == seed_prev_q);

    assign acc_d  = acc_q + GOLDEN;
    assign lane_d = lane_q + LANE_W'(1);

`ifdef SEED_LOAD_TIMEOUT_EN
    localparam int              TO_W    = $clog2(SYNC_TO_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(SYNC_TO_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q;

    // Sync-wait timer: held at zero outside WAIT_SYNC, so it restarts on entry.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            to_cnt_q <= '0;
        end else if (state_q != WAIT_SYNC) begin
            to_cnt_q <= '0;
        end else if (to_cnt_q != TO_LAST) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

    assign to_expired = (state_q == WAIT_SYNC) && (to_cnt_q == TO_LAST);
`else
    assign to_expired = 1'b0;
`endif

    // Sequencing FSM with registered outputs.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q        <= IDLE;
            shadow_q       <= 32'd0;
            latch_q        <= 32'd0;
            acc_q          <= 32'd0;
            lane_q         <= '0;
            ld_valid_q     <= 1'b0;
            ld_seed_q      <= 32'd0;
            busy_q         <= 1'b0;
            load_done_q    <= 1'b0;
            load_count_q   <= 16'd0;
            sync_timeout_q <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (seed_reg != shadow_q) begin
                        state_q <= SETTLE;
                        busy_q  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (seed_reg == shadow_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (settled) begin
                        latch_q <= seed_reg;
                        state_q <= WAIT_SYNC;
                    end
                end
                WAIT_SYNC: begin
                    // A sync coinciding with timer expiry counts as a real sync.
                    if (sync_in || to_expired) begin
                        state_q        <= LOAD;
                        sync_timeout_q <= !sync_in;
                        acc_q          <= latch_q;
                        lane_q         <= '0;
                        ld_valid_q     <= 1'b1;
                        ld_seed_q      <= guard_zero(latch_q);
                    end
                end
                LOAD: begin
                    if (ld_ready) begin
                        if (lane_q == LAST_LANE) begin
                            state_q      <= DONE;
                            ld_valid_q   <= 1'b0;
                            lane_q       <= '0;
                            acc_q        <= 32'd0;
                            ld_seed_q    <= 32'd0;
                            load_done_q  <= 1'b1;
                            load_count_q <= load_count_q + 16'd1;
                            shadow_q     <= latch_q;
                        end else begin
                            acc_q     <= acc_d;
                            lane_q    <= lane_d;
                            ld_seed_q <= guard_zero(acc_d);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
                    ld_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign ld_valid     = ld_valid_q;
    assign ld_lane      = lane_q;
    assign ld_seed      = ld_seed_q;
    assign busy         = busy_q;
    assign load_done    = load_done_q;
    assign load_count   = load_count_q;
    assign sync_timeout = sync_timeout_q;

endmodule

// File: tb/tb_seed_load_sequencer.sv
// Directed bench for seed_load_sequencer (N_LANES=8, STABLE_CYCLES=4,
// SYNC_TO_CYCLES=16). Accepted transfers are captured by a monitor and
// compared against hand-derived lane seeds.

module tb_seed_load_sequencer;

    localparam logic [31:0] GOLDEN = 32'h9E3779B9;

    logic        clk;
    logic        rst_n;
    logic [31:0] seed_reg;
    logic        sync_in;
    logic        ld_valid;
    logic [2:0]  ld_lane;
    logic [31:0] ld_seed;
    logic        ld_ready;
    logic        busy;
    logic        load_done;
    logic [15:0] load_count;
    logic        sync_timeout;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        logic [2:0]  lane;
        logic [31:0] seed;
    } xfer_t;

    xfer_t xq[$];

    seed_load_sequencer #(
        .N_LANES       (8),
        .LANE_W        (3),
        .STABLE_CYCLES (4),
        .SYNC_TO_CYCLES(16)
    ) dut (
        .user_clk    (clk),
        .user_rst_n  (rst_n),
        .seed_reg    (seed_reg),
        .sync_in     (sync_in),
        .ld_valid    (ld_valid),
        .ld_lane     (ld_lane),
        .ld_seed     (ld_seed),
        .ld_ready    (ld_ready),
        .busy        (busy),
        .load_done   (load_done),
        .load_count  (load_count),
        .sync_timeout(sync_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every transfer that will be accepted on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && ld_valid && ld_ready) begin
            xq.push_back('{lane: ld_lane, seed: ld_seed});
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lane_seed(input logic [31:0] base, input int i);
        logic [31:0] s;
        s = base + 32'(i) * GOLDEN;
        return (s == 32'd0) ? 32'd1 : s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sync();
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            cycles++;
            if (load_done) seen = 1'b1;
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_lanes(input string tag, input logic [31:0] base);
        chk({tag, "_nxfer"}, 32'(xq.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < xq.size()) begin
                chk({tag, "_lane"}, 32'(xq[i].lane), 32'(i));
                chk({tag, "_seed"}, xq[i].seed, lane_seed(base, i));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=0x00000000 exp=0x00000001");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int stalls;
        int n;

        rst_n    = 1'b0;
        seed_reg = 32'd0;
        sync_in  = 1'b0;
        ld_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(ld_valid), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(load_done), 32'd0);
        chk("rst_count", 32'(load_count), 32'd0);
        chk("rst_seed",  ld_seed, 32'd0);
        chk("rst_to",    32'(sync_timeout), 32'd0);
        rst_n = 1'b1;

        // seed_reg == 0 after reset matches the cleared shadow: no load.
        repeat (10) tick();
        chk("zero_idle", 32'(busy), 32'd0);

        // Basic load.
        xq.delete();
        seed_reg = 32'h0000_0001;
        repeat (10) tick();
        chk("basic_wait_busy",  32'(busy), 32'd1);
        chk("basic_wait_valid", 32'(ld_valid), 32'd0);
        pulse_sync();
        chk("basic_valid", 32'(ld_valid), 32'd1);
        chk("basic_lane0", 32'(ld_lane), 32'd0);
        chk("basic_seed0", ld_seed, 32'h0000_0001);
        wait_done(cyc);
        chk("basic_cycles", 32'(cyc), 32'd9);
        chk("basic_count", 32'(load_count), 32'd1);
        tick();
        chk("basic_idle", 32'(busy), 32'd0);
        chk("basic_done_cleared", 32'(load_done), 32'd0);
        check_lanes("basic", 32'h0000_0001);
        if (xq.size() > 1) chk("basic_lane1_seed", xq[1].seed, 32'h9E3779BA);

        // Zero guard.
        xq.delete();
        seed_reg = 32'h61C8_8647;
        repeat (10) tick();
        pulse_sync();
        wait_done(cyc);
        chk("zg_count", 32'(load_count), 32'd2);
        tick();
        check_lanes("zg", 32'h61C8_8647);
        if (xq.size() > 2) begin
            chk("zg_lane1_seed", xq[1].seed, 32'h0000_0001);
            chk("zg_lane2_seed", xq[2].seed, 32'h9E37_79B9);
        end

        // Glitch rejection: changes every 2 cycles never reach the stable count.
        xq.delete();
        seed_reg = 32'h5; repeat (2) tick();
        seed_reg = 32'h6; repeat (2) tick();
        seed_reg = 32'h5; repeat (2) tick();
        seed_reg = 32'h6; repeat (2) tick();
        seed_reg = 32'h5; tick();
        pulse_sync();
        chk("glitch_busy",  32'(busy), 32'd1);
        chk("glitch_no_ld", 32'(ld_valid), 32'd0);
        repeat (8) tick();
        chk("glitch_still_no_ld", 32'(ld_valid), 32'd0);
        pulse_sync();
        chk("glitch_valid", 32'(ld_valid), 32'd1);
        wait_done(cyc);
        chk("glitch_count", 32'(load_count), 32'd3);
        tick();
        check_lanes("glitch", 32'h5);

        // Backpressure: hold ld_ready low for 3 cycles on lane 3.
        xq.delete();
        seed_reg = 32'h1234_5678;
        repeat (10) tick();
        pulse_sync();
        stalls = 0;
        cyc    = 0;
        for (int i = 0; i < 60; i++) begin
            if (stalls > 0 && stalls < 3) begin
                chk("bp_hold_lane", 32'(ld_lane), 32'd3);
                chk("bp_hold_seed", ld_seed, lane_seed(32'h1234_5678, 3));
                ld_ready = 1'b0;
                stalls++;
            end else if (stalls == 0 && ld_valid && ld_lane == 3'd3) begin
                ld_ready = 1'b0;
                stalls   = 1;
            end else begin
                ld_ready = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (load_done) break;
            tick();
        end
        ld_ready = 1'b1;
        chk("bp_stalls", 32'(stalls), 32'd3);
        chk("bp_done", 32'(load_done), 32'd1);
        chk("bp_cycles", 32'(cyc), 32'd12);
        chk("bp_count", 32'(load_count), 32'd4);
        tick();
        check_lanes("bp", 32'h1234_5678);

        // Reset in the middle of a load abandons it.
        xq.delete();
        seed_reg = 32'h33;
        repeat (10) tick();
        pulse_sync();
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(ld_valid), 32'd0);
        chk("midrst_busy",  32'(busy), 32'd0);
        chk("midrst_count", 32'(load_count), 32'd0);
        chk("midrst_lane",  32'(ld_lane), 32'd0);
        seed_reg = 32'd0;
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("midrst_idle", 32'(busy), 32'd0);

        // Seed change during LOAD: old sequence completes, new one follows.
        xq.delete();
        seed_reg = 32'h0BAD_F00D;
        repeat (10) tick();
        pulse_sync();
        for (int i = 0; i < 20; i++) begin
            if (ld_lane == 3'd2) break;
            tick();
        end
        chk("mid_at_lane2", 32'(ld_lane), 32'd2);
        seed_reg = 32'h0000_00AA;
        wait_done(cyc);
        chk("mid_count1", 32'(load_count), 32'd1);
        check_lanes("mid_old", 32'h0BAD_F00D);
        xq.delete();
        repeat (10) tick();
        chk("mid_wait_busy",  32'(busy), 32'd1);
        chk("mid_wait_valid", 32'(ld_valid), 32'd0);
        pulse_sync();
        chk("mid_valid", 32'(ld_valid), 32'd1);
        wait_done(cyc);
        chk("mid_count2", 32'(load_count), 32'd2);
        tick();
        check_lanes("mid_new", 32'h0000_00AA);

`ifdef SEED_LOAD_TIMEOUT_EN
        // No sync: LOAD starts 16 cycles after WAIT_SYNC entry (4+2+16 after the change).
        xq.delete();
        seed_reg = 32'h77;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            n++;
            if (ld_valid) break;
        end
        chk("to_latency", 32'(n), 32'd22);
        chk("to_flag_set", 32'(sync_timeout), 32'd1);
        wait_done(cyc);
        tick();
        check_lanes("to", 32'h77);
        chk("to_flag_sticky", 32'(sync_timeout), 32'd1);
        xq.delete();
        seed_reg = 32'h78;
        repeat (10) tick();
        pulse_sync();
        chk("to_flag_clear", 32'(sync_timeout), 32'd0);
        wait_done(cyc);
        chk("to_count", 32'(load_count), 32'd4);
        tick();
`else
        n = 0;
        chk("to_tied_low", 32'(sync_timeout), 32'(n));
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
